// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, 7/8 data bits LSB-first, optional parity, stop, optional idle gap.
// Optional holding-register mode (accept mid-frame, back-to-back frames) enabled by UART_TX_HOLD_REG_EN.
module uart_tx_serializer #(
  parameter int unsigned TX_FRAME_GAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       xmit_pulse,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  // state | meaning (bit currently on txd)
  // IDLE  | line idle high, waiting for a pending byte
  // START | start bit (0)
  // DATA  | data bit bit_idx
  // PARITY| parity bit
  // STOP  | stop bit (1)
  // GAP   | extra idle bit periods after stop
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP} state_t;

  localparam logic [3:0] GAP_LAST = (TX_FRAME_GAP > 0) ? 4'(TX_FRAME_GAP - 1) : 4'd0;

  state_t     state, state_nxt;
  logic       pend_full;
  logic [7:0] pend_data;
  logic       pend_bit8, pend_par, pend_odd;
  logic [7:0] shift_data;
  logic       cfg_bit8, cfg_par, cfg_odd;
  logic [2:0] bit_idx, bit_idx_nxt;
  logic [3:0] gap_cnt, gap_cnt_nxt;
  logic       txd_nxt, done_nxt, load, frame_end, accept;
  logic [7:0] used_bits;
  logic [2:0] last_idx;
  logic       parity_bit;

`ifdef UART_TX_HOLD_REG_EN
  assign tx_ready = !pend_full;
`else
  assign tx_ready = !pend_full && (state == S_IDLE);
`endif

  assign accept     = tx_valid && tx_ready;
  assign used_bits  = cfg_bit8 ? shift_data : {1'b0, shift_data[6:0]};
  assign parity_bit = (^used_bits) ^ cfg_odd;
  assign last_idx   = cfg_bit8 ? 3'd7 : 3'd6;

  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    gap_cnt_nxt = gap_cnt;
    txd_nxt     = txd;
    done_nxt    = 1'b0;
    load        = 1'b0;
    frame_end   = 1'b0;
    if (xmit_pulse) begin
      case (state)
        S_IDLE: begin
          txd_nxt = 1'b1;
          if (pend_full) begin
            load      = 1'b1;
            state_nxt = S_START;
            txd_nxt   = 1'b0;
          end
        end
        S_START: begin
          state_nxt   = S_DATA;
          bit_idx_nxt = 3'd0;
          txd_nxt     = shift_data[0];
        end
        S_DATA: begin
          if (bit_idx == last_idx) begin
            if (cfg_par) begin
              state_nxt = S_PARITY;
              txd_nxt   = parity_bit;
            end else begin
              state_nxt = S_STOP;
              txd_nxt   = 1'b1;
            end
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            txd_nxt     = shift_data[bit_idx_nxt];
          end
        end
        S_PARITY: begin
          state_nxt = S_STOP;
          txd_nxt   = 1'b1;
        end
        S_STOP: begin
          if (TX_FRAME_GAP > 0) begin
            state_nxt   = S_GAP;
            gap_cnt_nxt = GAP_LAST;
            txd_nxt     = 1'b1;
          end else begin
            frame_end = 1'b1;
          end
        end
        S_GAP: begin
          txd_nxt = 1'b1;
          if (gap_cnt == 4'd0) frame_end = 1'b1;
          else                 gap_cnt_nxt = gap_cnt - 4'd1;
        end
        default: begin
          state_nxt = S_IDLE;
          txd_nxt   = 1'b1;
        end
      endcase
      // Last idle-level bit of the frame: chain straight into the next start if a byte waits.
      if (frame_end) begin
        done_nxt = 1'b1;
        if (pend_full) begin
          load      = 1'b1;
          state_nxt = S_START;
          txd_nxt   = 1'b0;
        end else begin
          state_nxt = S_IDLE;
          txd_nxt   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      txd        <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      pend_full  <= 1'b0;
      pend_data  <= 8'd0;
      pend_bit8  <= 1'b0;
      pend_par   <= 1'b0;
      pend_odd   <= 1'b0;
      shift_data <= 8'd0;
      cfg_bit8   <= 1'b0;
      cfg_par    <= 1'b0;
      cfg_odd    <= 1'b0;
      bit_idx    <= 3'd0;
      gap_cnt    <= 4'd0;
    end else begin
      state   <= state_nxt;
      txd     <= txd_nxt;
      tx_busy <= (state_nxt != S_IDLE);
      tx_done <= done_nxt;
      bit_idx <= bit_idx_nxt;
      gap_cnt <= gap_cnt_nxt;
      // load needs a full slot and accept needs an empty one, so they never coincide
      if (load) begin
        pend_full  <= 1'b0;
        shift_data <= pend_data;
        cfg_bit8   <= pend_bit8;
        cfg_par    <= pend_par;
        cfg_odd    <= pend_odd;
      end else if (accept) begin
        pend_full <= 1'b1;
        pend_data <= tx_data;
        pend_bit8 <= bit8;
        pend_par  <= parity_en;
        pend_odd  <= odd_n_even;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: two instances (gap 0 and gap 2) checked by a line-level
// receiver model that rebuilds each expected frame from the byte and its captured configuration.
module tb_uart_tx_serializer;

`ifdef UART_TX_HOLD_REG_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       b8;
    logic       pe;
    logic       odd;
  } item_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       xmit_pulse;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       bit8 = 1'b1, parity_en = 1'b0, odd_n_even = 1'b0;
  logic       valid_a, valid_b, ready_a, ready_b, txd_a, txd_b, busy_a, busy_b, done_a, done_b;
  logic [3:0] pcnt = 4'd0;
  int         sel = 0;
  int         n_checks = 0, n_errors = 0;
  int         dcnt_a = 0, dcnt_b = 0;
  logic       c_txd, c_busy, c_ready, c_done;
  int         c_dcnt;
  item_t      items[8];

  always #5 clk = ~clk;
  always @(posedge clk) pcnt <= pcnt + 4'd1;
  assign xmit_pulse = (pcnt == 4'd15);
  assign valid_a = tx_valid && (sel == 0);
  assign valid_b = tx_valid && (sel == 1);

  uart_tx_serializer #(.TX_FRAME_GAP(0)) u_g0 (
    .clk(clk), .reset(reset), .xmit_pulse(xmit_pulse), .tx_data(tx_data), .tx_valid(valid_a),
    .tx_ready(ready_a), .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .txd(txd_a), .tx_busy(busy_a), .tx_done(done_a));

  uart_tx_serializer #(.TX_FRAME_GAP(2)) u_g2 (
    .clk(clk), .reset(reset), .xmit_pulse(xmit_pulse), .tx_data(tx_data), .tx_valid(valid_b),
    .tx_ready(ready_b), .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .txd(txd_b), .tx_busy(busy_b), .tx_done(done_b));

  always @(negedge clk) begin
    if (done_a) dcnt_a <= dcnt_a + 1;
    if (done_b) dcnt_b <= dcnt_b + 1;
  end

  always_comb begin
    c_txd   = (sel == 1) ? txd_b   : txd_a;
    c_busy  = (sel == 1) ? busy_b  : busy_a;
    c_ready = (sel == 1) ? ready_b : ready_a;
    c_done  = (sel == 1) ? done_b  : done_a;
    c_dcnt  = (sel == 1) ? dcnt_b  : dcnt_a;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected line bits of one frame, start bit first.
  function automatic logic [15:0] ref_bits(input item_t it, input int gap, output int n);
    logic [15:0] v;
    int k, ones;
    v = '0;
    v[0] = 1'b0;
    k = 1;
    for (int i = 0; i < (it.b8 ? 8 : 7); i++) begin
      v[k] = it.d[i];
      k++;
    end
    if (it.pe) begin
      ones = $countones(it.b8 ? it.d : {1'b0, it.d[6:0]});
      v[k] = ((ones % 2) == 1) ^ it.odd;
      k++;
    end
    v[k] = 1'b1;
    k++;
    for (int g = 0; g < gap; g++) begin
      v[k] = 1'b1;
      k++;
    end
    n = k;
    return v;
  endfunction

  function automatic item_t rand_item();
    item_t it;
    it.d   = 8'($urandom);
    it.b8  = 1'($urandom);
    it.pe  = 1'($urandom);
    it.odd = 1'($urandom);
    return it;
  endfunction

  task automatic wait_mid();
    do @(negedge clk); while (pcnt != 4'd8);
  endtask

  // phase < 0: accept as soon as ready; otherwise accept on the edge leaving pcnt==phase.
  task automatic send_byte(input item_t it, input int phase);
    int w;
    w = 0;
    @(negedge clk);
    while (!(c_ready && (phase < 0 || int'(pcnt) == phase))) begin
      w++;
      if (w > 4000) begin
        check("send_timeout", 0, 1);
        return;
      end
      @(negedge clk);
    end
    tx_data    = it.d;
    bit8       = it.b8;
    parity_en  = it.pe;
    odd_n_even = it.odd;
    tx_valid   = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    check("ready_after_accept", c_ready, 0);
    tx_data = 8'($urandom);
    {bit8, parity_en, odd_n_even} = 3'($urandom);
  endtask

  task automatic rx_frame(input item_t it, input int gap, input int idle_min, input int idle_max,
                          input string tag);
    logic [15:0] v;
    int n, idle, d0;
    v = ref_bits(it, gap, n);
    idle = 0;
    wait_mid();
    while (c_txd !== 1'b0) begin
      idle++;
      if (idle > 60) begin
        check({tag, "_start_timeout"}, 0, 1);
        return;
      end
      wait_mid();
    end
    if (idle < idle_min || idle > idle_max) check({tag, "_idle_bits"}, idle, idle_min);
    else check({tag, "_idle_bits"}, idle, idle);
    check({tag, "_busy_start"}, c_busy, 1);
    d0 = c_dcnt;
    for (int k = 1; k < n; k++) begin
      wait_mid();
      check({tag, "_bit"}, c_txd, v[k]);
      check({tag, "_busy"}, c_busy, 1);
    end
    check({tag, "_done_early"}, c_dcnt - d0, 0);
    repeat (9) @(negedge clk);
    check({tag, "_done"}, c_dcnt - d0, 1);
  endtask

  task automatic run_stream(input int n, input int gap);
    fork
      begin
        for (int i = 0; i < n; i++) send_byte(items[i], -1);
      end
      begin
        for (int i = 0; i < n; i++) begin
          if (i == 0) rx_frame(items[i], gap, 0, 1, "stream");
          else if (HOLD) rx_frame(items[i], gap, 0, 0, "stream");
          else rx_frame(items[i], gap, 1, 1, "stream");
        end
      end
    join
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    item_t it;
    int ph, w;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd_a", txd_a, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_ready_a", ready_a, 1);
    check("rst_done_a", done_a, 0);
    check("rst_txd_b", txd_b, 1);
    check("rst_busy_b", busy_b, 0);
    check("rst_ready_b", ready_b, 1);
    check("rst_done_b", done_b, 0);
    @(negedge clk);
    reset = 1'b0;

    sel = 0;
    it = '{8'h55, 1'b1, 1'b0, 1'b0};
    send_byte(it, 2);
    rx_frame(it, 0, 1, 1, "x55");
    it = '{8'hA3, 1'b0, 1'b1, 1'b1};
    send_byte(it, 10);
    rx_frame(it, 0, 0, 0, "xA3_odd");
    it = '{8'hA3, 1'b0, 1'b1, 1'b0};
    send_byte(it, 12);
    rx_frame(it, 0, 0, 0, "xA3_even");

    // Accept coincident with xmit_pulse: one idle bit period before the start bit.
    it = rand_item();
    send_byte(it, 15);
    rx_frame(it, 0, 1, 1, "coincident");

    for (int i = 0; i < 6; i++) begin
      it = rand_item();
      ph = int'($urandom_range(0, 15));
      send_byte(it, ph);
      if (ph <= 7 || ph == 15) rx_frame(it, 0, 1, 1, "rand_single");
      else rx_frame(it, 0, 0, 0, "rand_single");
    end

    for (int i = 0; i < 5; i++) items[i] = rand_item();
    run_stream(5, 0);

    sel = 1;
    items[0] = '{8'h00, 1'b1, 1'b0, 1'b0};
    items[1] = '{8'hFF, 1'b1, 1'b0, 1'b0};
    run_stream(2, 2);
    for (int i = 0; i < 4; i++) items[i] = rand_item();
    run_stream(4, 2);

    // Reset in the middle of data bit 3 of 0x0F aborts the frame.
    sel = 0;
    it = '{8'h0F, 1'b1, 1'b0, 1'b0};
    send_byte(it, 2);
    w = 0;
    wait_mid();
    while (c_txd !== 1'b0 && w < 40) begin
      w++;
      wait_mid();
    end
    check("rst_mid_start_seen", c_txd, 0);
    ph = c_dcnt;
    repeat (4) wait_mid();
    check("rst_mid_bit3", c_txd, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_txd", c_txd, 1);
    check("rst_mid_busy", c_busy, 0);
    check("rst_mid_ready", c_ready, 1);
    check("rst_mid_done", c_done, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_mid();
      check("rst_mid_line_idle", c_txd, 1);
      check("rst_mid_busy_idle", c_busy, 0);
    end
    check("rst_mid_no_done", c_dcnt - ph, 0);
    it = rand_item();
    send_byte(it, 3);
    rx_frame(it, 0, 1, 1, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
